piso_shifter: RTL
=================

// Module: piso_shifter
// PURPOSE
//  Parallel-in / serial-out shifter, the transmit side of the button-to-LED serial-in shift demo.
//  Captures a WIDTH-bit word on a LOAD strobe and shifts it out on SER_OUT, one bit per divided-clock tick.
//  Sits between the button/switch inputs and a serial LED or pin, so a serial-in shift register can receive the word.
//  Supplies BUSY/DONE status for a top-level sequencer.
// PARAMETERS
//  WIDTH     5        word length in bits; legal range >= 2
//  TICK_DIV  2000000  bit period is TICK_DIV+1 CLK cycles; legal range >= 1
// PORTS
//  CLK        in   1      system clock; all state changes on its rising edge
//  RST_N      in   1      asynchronous, active-low reset
//  LOAD       in   1      single-cycle load strobe; sampled on the rising edge of CLK
//  LOAD_DATA  in   WIDTH  word captured when LOAD is accepted
//  SER_OUT    out  1      serial data; 0 when idle
//  BUSY       out  1      high while a word is being shifted
//  DONE       out  1      one-cycle pulse after the last bit period ends
// BEHAVIOUR
//  Reset (RST_N=0, asynchronous): state=IDLE; divider, bit count and shift reg = 0.
//   Outputs after reset: SER_OUT=0, BUSY=0, DONE=0.
//   Reset mid-word aborts the word immediately; there is no partial-word completion after release.
//  FSM states: IDLE, SHIFT.
//  IDLE:
//   LOAD=1 at edge t0 -> shift reg <= LOAD_DATA, divider <= 0, bit count <= 0, state <= SHIFT.
//   LOAD=0 -> state stays IDLE; SER_OUT=0, BUSY=0.
//  SHIFT:
//   BUSY=1 from t0+1.
//   SER_OUT = current output bit of the shift reg (registered output, no combinational path from LOAD).
//   Divider counts 0..TICK_DIV and then wraps to 0.
//   On wrap: shift reg shifts one place and bit count increments.
//   Bit k (k = 0..WIDTH-1) drives SER_OUT for cycles t0+1+k*(TICK_DIV+1) through t0+(k+1)*(TICK_DIV+1).
//   On the wrap that completes bit WIDTH-1, at edge t0+WIDTH*(TICK_DIV+1):
//    state <= IDLE, SER_OUT <= 0, BUSY <= 0, DONE <= 1 for exactly one cycle.
//  Total latency from LOAD to DONE: WIDTH*(TICK_DIV+1) cycles.
//  LOAD while BUSY=1 (including the final cycle of the last bit): ignored; LOAD_DATA is not captured.
//  LOAD in the DONE cycle: accepted, because state is already IDLE.
//   That cycle gives back-to-back words with no idle bit period between them.
//  LOAD_DATA is don't-care except on the accepting edge.
//  Widths: divider $clog2(TICK_DIV+1) bits; bit count $clog2(WIDTH+1) bits. No overflow is possible.
// CONFIGURATION
//  PISO_LSB_FIRST_EN undefined (default): MSB first.
//   Bit k on SER_OUT = LOAD_DATA[WIDTH-1-k].
//   A matching serial-in shifter (input at bit 0, shifting upward) then holds LOAD_DATA unchanged.
//  PISO_LSB_FIRST_EN defined: LSB first; bit k on SER_OUT = LOAD_DATA[k].
//   Timing, BUSY and DONE are identical in both builds.
// TESTING
//  Bench parameters: WIDTH=5, TICK_DIV=3, so the bit period is 4 cycles.
//  1. Reset, then LOAD=1 with LOAD_DATA=5'b10110 at t0 -> expected:
//     SER_OUT = 1,0,1,1,0, each bit held 4 cycles starting at t0+1;
//     BUSY=1 over t0+1..t0+20; DONE=1 only at t0+21; SER_OUT=0 from t0+21.
//  2. Same stimulus with PISO_LSB_FIRST_EN defined -> SER_OUT = 0,1,1,0,1; timing and DONE unchanged.
//  3. LOAD pulses with 5'b11111 at t0+5 and at t0+20 during a word -> ignored; the original word completes unchanged.
//  4. LOAD with 5'b00001 in the DONE cycle -> second word starts; its first bit (0, MSB-first) appears next cycle;
//     DONE again 20 cycles later.
//  5. RST_N=0 asynchronously at t0+9 -> SER_OUT, BUSY, DONE = 0 at once, with no clock edge needed;
//     after release, outputs stay idle until the next LOAD.
//  6. Loopback: SER_OUT into a 5-bit serial-in shifter clocked on the same tick; for 32 random words,
//     the receiver word equals LOAD_DATA at DONE (MSB-first build).

Source files
------------

// File: rtl/piso_shifter.sv
// piso_shifter - parallel-in/serial-out shifter with divided bit period and BUSY/DONE status.
// Build option: define PISO_LSB_FIRST_EN for LSB-first output (default MSB first).
module piso_shifter #(
  parameter int WIDTH    = 5,
  parameter int TICK_DIV = 2000000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  output logic             o_ser_out,
  output logic             o_busy,
  output logic             o_done
);

  localparam int DIV_W = $clog2(TICK_DIV + 1);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_busy;
  logic             r_done;

  logic             w_wrap;
  logic             w_last;
  logic [WIDTH-1:0] w_shifted;
  logic             w_out_bit;

  assign w_wrap = (r_div == DIV_MAX);
  assign w_last = (r_cnt == CNT_LAST);

  // The output bit is read straight from the shift register, so SER_OUT is
  // registered and returns to 0 once the register has been cleared.
`ifdef PISO_LSB_FIRST_EN
  assign w_out_bit = r_shift[0];
  assign w_shifted = {1'b0, r_shift[WIDTH-1:1]};
`else
  assign w_out_bit = r_shift[WIDTH-1];
  assign w_shifted = {r_shift[WIDTH-2:0], 1'b0};
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          if (i_load) begin
            r_shift <= i_load_data;
            r_div   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_wrap) begin
            r_div <= '0;
            if (w_last) begin
              r_shift <= '0;
              r_cnt   <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_shift <= w_shifted;
              r_cnt   <= r_cnt + CNT_W'(1);
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ser_out = w_out_bit;
  assign o_busy    = r_busy;
  assign o_done    = r_done;

endmodule
